// File: rtl/data_mem_responder.sv
// Data-side load/store responder: serialized word-array accesses with a
// configurable wait-state count, byte-lane writes and a registered read port.

module data_mem_lane #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic [3:0]  we_mem,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        read_valid,
    output logic [31:0] read_data,
    output logic        error
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned NUM_LANES = 4;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]                 state;
    logic [3:0]                 cnt;
    logic                       op_wr;
    logic                       collide;
    logic                       in_range_q;
    logic [AW-1:0]              idx_q;
    logic [NUM_LANES-1:0]       we_q;
    logic [NUM_LANES-1:0][7:0]  wd_q;
    logic [NUM_LANES-1:0][7:0]  rd_word;

    logic        is_wr;
    logic        req;
    logic        done;
    logic [31:0] addr;
    logic [31:0] offset;

    // A write wins the address decode when both ops arrive together.
    assign is_wr  = |we_mem;
    assign req    = read | is_wr;
    assign addr   = is_wr ? write_address : read_address;
    assign offset = addr - BASE_ADDR;
    assign done   = (state == ACCESS) && (cnt == 4'd0);
    assign busy   = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            read_valid <= 1'b0;
            read_data  <= 32'd0;
            error      <= 1'b0;
            op_wr      <= 1'b0;
            collide    <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            we_q       <= '0;
            wd_q       <= '0;
        end else begin
            read_valid <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr      <= is_wr;
                        collide    <= read & is_wr;
                        in_range_q <= {1'b0, offset} < SPAN;
                        idx_q      <= offset[AW+1:2];
                        we_q       <= we_mem;
                        wd_q       <= write_data;
                        cnt        <= 4'(WAIT_STATES);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        error <= ~in_range_q | collide;
                        if (!op_wr) begin
                            read_valid <= 1'b1;
                            read_data  <= in_range_q ? rd_word : 32'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating the commit with reset drops a write caught mid-access.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        data_mem_lane #(
            .DEPTH_WORDS (DEPTH_WORDS),
            .AW          (AW)
        ) u_lane (
            .clk   (clk),
            .wr_en (reset & done & op_wr & in_range_q & we_q[g]),
            .idx   (idx_q),
            .wdata (wd_q[g]),
            .rdata (rd_word[g])
        );
    end
endmodule
